// File: rtl/usrf_n.sv
// Universal shift register with manual single-cycle operations and an FSM-driven
// burst mode that performs n shifts in a latched direction, then pulses done.
module usrf_n #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             c,
    input  logic             r,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic             dir,
    input  logic [CNTW-1:0]  n,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNTW-1:0] cnt;
    logic            dir_lat;

    function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] v, input logic s);
        return {s, v[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v, input logic s);
        return {v[WIDTH-2:0], s};
    endfunction

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt holds the shifts still to do, so the last RUN cycle is the one with cnt==1
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == CNTW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            q       <= '0;
            cnt     <= '0;
            dir_lat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= n;
                        dir_lat <= dir;
                    end else if (en) begin
                        case (mode)
                            2'b01:   q <= shr(q, sin_r);
                            2'b10:   q <= shl(q, sin_l);
                            2'b11:   q <= pin;
                            default: q <= q;
                        endcase
                    end
                end
                RUN: begin
                    q   <= dir_lat ? shl(q, sin_l) : shr(q, sin_r);
                    cnt <= cnt - CNTW'(1);
                end
                default: begin
                    q <= q;
                end
            endcase
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_usrf_n.sv
// Bench for usrf_n: directed vector table, async reset mid-burst sequence,
// and randomized operation against a behavioural model.
module tb_usrf_n;

    localparam int WIDTH = 4;
    localparam int CNTW  = 3;

    logic             c;
    logic             r;
    logic             en;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic             start;
    logic             dir;
    logic [CNTW-1:0]  n;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    usrf_n #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .c(c), .r(r), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pin(pin), .start(start), .dir(dir), .n(n), .q(q),
        .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       sr;
        logic       sl;
        logic [3:0] pin;
        logic       st;
        logic       dr;
        logic [2:0] nn;
        logic [3:0] eq;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input logic [1:0] m, input logic sr,
                                input logic sl, input logic [3:0] p, input logic st,
                                input logic dr, input logic [2:0] nn, input logic [3:0] eq,
                                input logic eb, input logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.sr = sr; v.sl = sl; v.pin = p; v.st = st;
        v.dr = dr; v.nn = nn; v.eq = eq; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eq, input logic eb,
                              input logic ed);
        check({tag, " q"}, 32'(q), 32'(eq));
        check({tag, " busy"}, 32'(busy), 32'(eb));
        check({tag, " done"}, 32'(done), 32'(ed));
        check({tag, " sout_r"}, 32'(sout_r), 32'(eq[0]));
        check({tag, " sout_l"}, 32'(sout_l), 32'(eq[3]));
    endtask

    task automatic drive_idle();
        en = 0; mode = 2'b00; sin_r = 0; sin_l = 0; pin = '0;
        start = 0; dir = 0; n = '0;
    endtask

    // Behavioural reference: a register value plus "shifts remaining" and a done flag.
    int mq, m_rem, m_dir, m_done;

    task automatic model_step();
        if (m_rem > 0) begin
            if (m_dir != 0) mq = ((mq * 2) + int'(sin_l)) % (1 << WIDTH);
            else            mq = (mq / 2) + int'(sin_r) * (1 << (WIDTH - 1));
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end else if (m_done != 0) begin
            m_done = 0;
        end else if (start) begin
            if (n == 0) m_done = 1;
            else begin
                m_rem = int'(n);
                m_dir = int'(dir);
            end
        end else if (en) begin
            case (mode)
                2'b01: mq = (mq / 2) + int'(sin_r) * (1 << (WIDTH - 1));
                2'b10: mq = ((mq * 2) + int'(sin_l)) % (1 << WIDTH);
                2'b11: mq = int'(pin);
                default: ;
            endcase
        end
    endtask

    initial begin
        drive_idle();
        r = 1'b0;
        #12;
        check_outs("reset", 4'b0000, 1'b0, 1'b0);
        r = 1'b1;
        @(posedge c); #1;

        //        en mode sr sl pin    st dr n     exp_q  b  d
        tbl.push_back(mk(1, 2'b11, 0, 0, 4'b1010, 0, 0, 3'd0, 4'b1010, 0, 0));
        tbl.push_back(mk(1, 2'b01, 1, 0, 4'b0000, 0, 0, 3'd0, 4'b1101, 0, 0));
        tbl.push_back(mk(1, 2'b11, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 2'b01, 1, 0, 4'b0000, 0, 0, 3'd0, 4'b1000, 0, 0));
        tbl.push_back(mk(1, 2'b01, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b0100, 0, 0));
        tbl.push_back(mk(1, 2'b01, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b0010, 0, 0));
        tbl.push_back(mk(1, 2'b01, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 0, 4'b1111, 0, 0, 3'd0, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 1, 1, 3'd3, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 2'b11, 0, 0, 4'b1111, 1, 0, 3'd1, 4'b0010, 1, 0));
        tbl.push_back(mk(0, 2'b00, 1, 0, 4'b0000, 1, 0, 3'd2, 4'b0100, 1, 0));
        tbl.push_back(mk(0, 2'b00, 1, 0, 4'b0000, 0, 0, 3'd0, 4'b1000, 0, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 1, 0, 3'd2, 4'b1000, 0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 1, 0, 3'd0, 4'b1000, 0, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b1000, 0, 0));
        tbl.push_back(mk(1, 2'b11, 0, 0, 4'b0101, 1, 0, 3'd2, 4'b1000, 1, 0));
        tbl.push_back(mk(0, 2'b00, 1, 0, 4'b0000, 0, 0, 3'd0, 4'b1100, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b0110, 0, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b0110, 0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 1, 1, 3'd7, 4'b0110, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 1, 4'b0000, 0, 0, 3'd0, 4'b1101, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b1010, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 1, 4'b0000, 0, 0, 3'd0, 4'b0101, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 1, 4'b0000, 0, 0, 3'd0, 4'b1011, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b0110, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b1100, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 1, 4'b0000, 0, 0, 3'd0, 4'b1001, 0, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b1001, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; mode = tbl[i].mode; sin_r = tbl[i].sr; sin_l = tbl[i].sl;
            pin = tbl[i].pin; start = tbl[i].st; dir = tbl[i].dr; n = tbl[i].nn;
            @(posedge c); #1;
            check_outs($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eb, tbl[i].ed);
        end

        // Reset mid-burst: load 0011, start n=5 right, two shifts, then async reset.
        drive_idle();
        en = 1; mode = 2'b11; pin = 4'b0011;
        @(posedge c); #1;
        check_outs("abort load", 4'b0011, 1'b0, 1'b0);
        drive_idle();
        start = 1; dir = 0; n = 3'd5;
        @(posedge c); #1;
        drive_idle();
        sin_r = 1;
        @(posedge c); #1;
        @(posedge c); #1;
        check_outs("abort 2 shifts", 4'b1100, 1'b1, 1'b0);
        #3;
        r = 1'b0;
        #1;
        check_outs("abort async", 4'b0000, 1'b0, 1'b0);
        @(posedge c); #1;
        check_outs("abort held", 4'b0000, 1'b0, 1'b0);
        r = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge c); #1;
            check_outs($sformatf("abort after%0d", k), 4'b0000, 1'b0, 1'b0);
        end
        en = 1; mode = 2'b11; pin = 4'b1010;
        @(posedge c); #1;
        check_outs("abort reload", 4'b1010, 1'b0, 1'b0);

        // Randomized run against the behavioural model.
        drive_idle();
        r = 1'b0;
        #3;
        r = 1'b1;
        mq = 0; m_rem = 0; m_dir = 0; m_done = 0;
        for (int k = 0; k < 3000; k++) begin
            en    = 1'($urandom_range(0, 1));
            mode  = 2'($urandom_range(0, 3));
            sin_r = 1'($urandom_range(0, 1));
            sin_l = 1'($urandom_range(0, 1));
            pin   = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 5) == 0);
            dir   = 1'($urandom_range(0, 1));
            n     = 3'($urandom_range(0, 7));
            model_step();
            @(posedge c); #1;
            check_outs($sformatf("rnd%0d", k), 4'(mq), (m_rem > 0), (m_done != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
